rv32_bus_arbiter: RTL and testbench
===================================

# rv32_bus_arbiter

Two-port to single-port memory arbiter for the rv32 core. It shares one memory bus between the fetch stage's instruction port and the mem stage's data port. It owns arbitration state, request latching, and the response handshake back to each stage, so fetch and mem can both run against one unified memory. Data requests have priority, and a bounded burst counter prevents fetch starvation.

## Interface
- MAX_DATA_BURST, default 4: maximum consecutive data grants while an instruction request is pending (valid range 1-15).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid_in  in  1  fetch request pending.
- instr_address_in  in  32  fetch byte address, word-aligned.
- instr_ready_out  out  1  fetch transaction completes this cycle.
- instr_read_value_out  out  32  fetched word; valid while instr_ready_out=1.
- data_valid_in  in  1  mem-stage request pending.
- data_address_in  in  32  data byte address, word-aligned.
- data_write_mask_in  in  4  byte write enables; 0 means read.
- data_write_value_in  in  32  store data, pre-shifted to byte lanes.
- data_ready_out  out  1  data transaction completes this cycle.
- data_read_value_out  out  32  loaded word; valid while data_ready_out=1.
- bus_valid_out  out  1  shared-bus request.
- bus_address_out  out  32  latched address.
- bus_write_mask_out  out  4  latched write mask; 0 for instruction grants.
- bus_write_value_out  out  32  latched store data; 0 for instruction grants.
- bus_ready_in  in  1  bus completes the current request this cycle.
- bus_read_value_in  in  32  read data; valid with bus_ready_in.

## Operation
- States: IDLE, INSTR, DATA. Reset state is IDLE.
- IDLE grant rules:
  - If data_valid_in=1 and (instr_valid_in=0 or burst_count<MAX_DATA_BURST): grant data and go to DATA.
  - Otherwise, if instr_valid_in=1: grant instruction and go to INSTR.
  - Otherwise: stay in IDLE.
- On a grant, latch address, mask, and value into the bus_* registers and set bus_valid_out=1.
- INSTR/DATA:
  - Hold bus_valid_out and all bus_* fields stable until bus_ready_in=1.
  - In the bus_ready_in cycle, assert the owner's ready_out combinationally and pass bus_read_value_in through to the owner's read_value_out.
  - On the next edge: clear bus_valid_out and return to IDLE.
- The mandatory IDLE cycle after completion exists because the completing requester's valid is still high in its ready cycle and must not be re-granted.
- Non-owner ready_out is always 0. Read-value outputs are 0 whenever the corresponding ready_out is 0.
- burst_count, width 4, unsigned:
  - Increments, saturating at MAX_DATA_BURST, on a data grant with instr_valid_in=1.
  - Clears to 0 on any instruction grant, or on a data grant with instr_valid_in=0.
- Requesters must hold valid and request fields stable until they see their ready. The arbiter samples request fields only at the grant edge.
- A requester that drops valid before being granted is simply not granted; there is no error.

## Timing
- Reset, asynchronous: state=IDLE, burst_count=0, bus_valid_out=0, bus_address_out=0, bus_write_mask_out=0, bus_write_value_out=0. All ready_out and read_value_out are 0.
- Grant latency: valid high in an IDLE cycle at edge t gives bus_valid_out=1 from t+1.
- Minimum transaction, with bus_ready_in already high: 2 cycles (IDLE, then INSTR/DATA with ready). Peak bus utilisation is 50%.
- Both requests pending with MAX_DATA_BURST=4: data, data, data, data, instr, data, and so on.
- Reset asserted mid-transaction: bus_valid_out and ready outputs drop immediately. The in-flight request is abandoned, with no ready issued.
- bus_ready_in while in IDLE is ignored.

## Test plan
- Instruction only:
  - Stimulus: instr_valid_in=1, address 0x100, bus_ready_in=1 one cycle after bus_valid_out rises, bus_read_value_in=0x00000013.
  - Required: bus_valid_out=1 at t+1 with address 0x100 and mask 0; instr_ready_out=1 with value 0x13 at t+2; back to IDLE.
- Data write:
  - Stimulus: address 0x2004, mask 4'b0011, value 0xBEEF, bus_ready_in held low for 3 cycles.
  - Required: bus fields stable for all 4 busy cycles; data_ready_out pulses exactly once; instr_ready_out stays 0 throughout.
- Simultaneous requests, both valid continuously, bus always ready:
  - MAX_DATA_BURST=4: grant order D,D,D,D,I,D,D,D,D,I.
  - MAX_DATA_BURST=1: strict alternation D,I,D,I.
- Burst counter clearing:
  - Stimulus: 3 data grants while instr pending, then instr_valid drops for one data grant, then instr returns.
  - Required: burst_count is 0 after the fourth grant; the next 4 grants are data before instr.
- Asynchronous reset mid-transaction:
  - Stimulus: assert reset in DATA state between clock edges.
  - Required: bus_valid_out=0 within the same cycle; after release, state is IDLE and the first grant follows the IDLE rules with burst_count=0.
- Early withdrawal:
  - Stimulus: instr_valid_in pulses for one cycle while a data transaction is busy.
  - Required: no instruction grant occurs; bus_address_out never shows the instruction address.

Source files
------------

// File: rtl/rv32_bus_arbiter.sv
// Shares one memory bus between the fetch (instruction) and mem (data) ports.
// Data has priority; a saturating burst counter bounds how long fetch can wait.
module rv32_bus_arbiter #(
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid_in,
    input  logic [31:0] instr_address_in,
    output logic        instr_ready_out,
    output logic [31:0] instr_read_value_out,
    input  logic        data_valid_in,
    input  logic [31:0] data_address_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_write_value_in,
    output logic        data_ready_out,
    output logic [31:0] data_read_value_out,
    output logic        bus_valid_out,
    output logic [31:0] bus_address_out,
    output logic [3:0]  bus_write_mask_out,
    output logic [31:0] bus_write_value_out,
    input  logic        bus_ready_in,
    input  logic [31:0] bus_read_value_in
);

    typedef enum logic [1:0] {S_IDLE, S_INSTR, S_DATA} state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_DATA_BURST);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_burst_count;
    logic        r_bus_valid;
    logic [31:0] r_bus_address;
    logic [3:0]  r_bus_write_mask;
    logic [31:0] r_bus_write_value;
    logic        w_grant_data;
    logic        w_grant_instr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state         = r_state;
        w_grant_data         = 1'b0;
        w_grant_instr        = 1'b0;
        instr_ready_out      = 1'b0;
        instr_read_value_out = '0;
        data_ready_out       = 1'b0;
        data_read_value_out  = '0;
        case (r_state)
            S_IDLE: begin
                if (data_valid_in && (!instr_valid_in || (r_burst_count < BURST_LIMIT))) begin
                    w_grant_data = 1'b1;
                    w_next_state = S_DATA;
                end else if (instr_valid_in) begin
                    w_grant_instr = 1'b1;
                    w_next_state  = S_INSTR;
                end
            end
            S_INSTR: begin
                if (bus_ready_in) begin
                    instr_ready_out      = 1'b1;
                    instr_read_value_out = bus_read_value_in;
                    w_next_state         = S_IDLE;
                end
            end
            S_DATA: begin
                if (bus_ready_in) begin
                    data_ready_out      = 1'b1;
                    data_read_value_out = bus_read_value_in;
                    w_next_state        = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request fields are captured only at the grant edge; they stay latched after completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_valid       <= 1'b0;
            r_bus_address     <= '0;
            r_bus_write_mask  <= '0;
            r_bus_write_value <= '0;
        end else if (w_grant_data) begin
            r_bus_valid       <= 1'b1;
            r_bus_address     <= data_address_in;
            r_bus_write_mask  <= data_write_mask_in;
            r_bus_write_value <= data_write_value_in;
        end else if (w_grant_instr) begin
            r_bus_valid       <= 1'b1;
            r_bus_address     <= instr_address_in;
            r_bus_write_mask  <= '0;
            r_bus_write_value <= '0;
        end else if ((r_state != S_IDLE) && bus_ready_in) begin
            r_bus_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst_count <= '0;
        end else if (w_grant_data && instr_valid_in) begin
            if (r_burst_count < BURST_LIMIT) r_burst_count <= r_burst_count + 4'd1;
        end else if (w_grant_data || w_grant_instr) begin
            r_burst_count <= '0;
        end
    end

    assign bus_valid_out       = r_bus_valid;
    assign bus_address_out     = r_bus_address;
    assign bus_write_mask_out  = r_bus_write_mask;
    assign bus_write_value_out = r_bus_write_value;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Self-checking bench for rv32_bus_arbiter: directed vectors, grant-order sequences,
// async reset, and random traffic against a transaction-level reference model.
module tb_rv32_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        t_iv;
    logic [31:0] t_ia;
    logic        t_dv;
    logic [31:0] t_da;
    logic [3:0]  t_dm;
    logic [31:0] t_dw;
    logic        t_br;
    logic [31:0] t_brv;

    logic        a_ir, a_dr, a_bv, b_ir, b_dr, b_bv;
    logic [31:0] a_ird, a_drd, a_ba, a_bw, b_ird, b_drd, b_ba, b_bw;
    logic [3:0]  a_bm, b_bm;

    int n_checks = 0;
    int n_errors = 0;

    rv32_bus_arbiter #(.MAX_DATA_BURST(4)) dut_a (
        .clk(clk), .reset(reset),
        .instr_valid_in(t_iv), .instr_address_in(t_ia),
        .instr_ready_out(a_ir), .instr_read_value_out(a_ird),
        .data_valid_in(t_dv), .data_address_in(t_da),
        .data_write_mask_in(t_dm), .data_write_value_in(t_dw),
        .data_ready_out(a_dr), .data_read_value_out(a_drd),
        .bus_valid_out(a_bv), .bus_address_out(a_ba),
        .bus_write_mask_out(a_bm), .bus_write_value_out(a_bw),
        .bus_ready_in(t_br), .bus_read_value_in(t_brv)
    );

    rv32_bus_arbiter #(.MAX_DATA_BURST(1)) dut_b (
        .clk(clk), .reset(reset),
        .instr_valid_in(t_iv), .instr_address_in(t_ia),
        .instr_ready_out(b_ir), .instr_read_value_out(b_ird),
        .data_valid_in(t_dv), .data_address_in(t_da),
        .data_write_mask_in(t_dm), .data_write_value_in(t_dw),
        .data_ready_out(b_dr), .data_read_value_out(b_drd),
        .bus_valid_out(b_bv), .bus_address_out(b_ba),
        .bus_write_mask_out(b_bm), .bus_write_value_out(b_bw),
        .bus_ready_in(t_br), .bus_read_value_in(t_brv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [3:0]  dm;
        logic [31:0] dw;
        logic        br;
        logic [31:0] brv;
        logic        e_bv;
        logic [31:0] e_ba;
        logic [3:0]  e_bm;
        logic [31:0] e_bw;
        logic        e_ir;
        logic [31:0] e_ird;
        logic        e_dr;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs[10];

    // Reference model: who owns the bus, how many data grants in a row fetch has waited out.
    int          m_owner[2];   // 0 none, 1 instruction, 2 data
    int          m_streak[2];
    int          m_max[2];
    logic [31:0] m_addr[2];
    logic [3:0]  m_mask[2];
    logic [31:0] m_val[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic [31:0] da,
                         input logic [3:0] dm, input logic [31:0] dw, input logic br, input logic [31:0] brv);
        t_iv = iv; t_ia = ia; t_dv = dv; t_da = da; t_dm = dm; t_dw = dw; t_br = br; t_brv = brv;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = 0; m_streak[k] = 0;
            m_addr[k] = '0; m_mask[k] = '0; m_val[k] = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (m_owner[k] == 0) begin
                if (t_dv && (!t_iv || m_streak[k] < m_max[k])) begin
                    m_owner[k] = 2;
                    m_addr[k] = t_da; m_mask[k] = t_dm; m_val[k] = t_dw;
                    m_streak[k] = t_iv ? ((m_streak[k] + 1 > m_max[k]) ? m_max[k] : m_streak[k] + 1) : 0;
                end else if (t_iv) begin
                    m_owner[k] = 1;
                    m_addr[k] = t_ia; m_mask[k] = '0; m_val[k] = '0;
                    m_streak[k] = 0;
                end
            end else if (t_br) begin
                m_owner[k] = 0;
            end
        end
    endtask

    task automatic cmp_model(input int k, input logic bv, input logic [31:0] ba, input logic [3:0] bm,
                             input logic [31:0] bw, input logic ir, input logic [31:0] ird,
                             input logic dr, input logic [31:0] drd);
        logic e_ir, e_dr;
        e_ir = (m_owner[k] == 1) && t_br;
        e_dr = (m_owner[k] == 2) && t_br;
        chk($sformatf("rnd%0d bus_valid", k), 32'(bv), 32'(m_owner[k] != 0));
        chk($sformatf("rnd%0d bus_address", k), ba, m_addr[k]);
        chk($sformatf("rnd%0d bus_mask", k), 32'(bm), 32'(m_mask[k]));
        chk($sformatf("rnd%0d bus_value", k), bw, m_val[k]);
        chk($sformatf("rnd%0d instr_ready", k), 32'(ir), 32'(e_ir));
        chk($sformatf("rnd%0d instr_rdata", k), ird, e_ir ? t_brv : 32'h0);
        chk($sformatf("rnd%0d data_ready", k), 32'(dr), 32'(e_dr));
        chk($sformatf("rnd%0d data_rdata", k), drd, e_dr ? t_brv : 32'h0);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Run n cycles with both requesters asking; record each instance's grant letters.
    task automatic grant_run(input int n, input int drop_cycle, output string sa, output string sb);
        sa = "";
        sb = "";
        for (int c = 0; c < n; c++) begin
            drive(c != drop_cycle, 32'h1000, 1'b1, 32'h2000, 4'hF, 32'h0, 1'b1, 32'h0);
            @(negedge clk);
            if (a_bv && a_ir) sa = {sa, "I"};
            if (a_bv && a_dr) sa = {sa, "D"};
            if (b_bv && b_ir) sb = {sb, "I"};
            if (b_bv && b_dr) sb = {sb, "D"};
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        string sa, sb;
        m_max[0] = 4;
        m_max[1] = 1;
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0);

        vecs[0] = '{1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h13,
                    1'b1, 32'h100, 4'h0, 32'h0, 1'b1, 32'h13, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hDEAD,
                    1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 32'h2004, 4'h3, 32'hBEEF, 1'b0, 32'h0,
                    1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 32'h0, 1'b1, 32'h2004, 4'h3, 32'hBEEF, 1'b0, 32'h0,
                    1'b1, 32'h2004, 4'h3, 32'hBEEF, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'h300, 1'b1, 32'h2004, 4'h3, 32'hBEEF, 1'b0, 32'h0,
                    1'b1, 32'h2004, 4'h3, 32'hBEEF, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 32'h0, 1'b1, 32'h2004, 4'h3, 32'hBEEF, 1'b0, 32'h0,
                    1'b1, 32'h2004, 4'h3, 32'hBEEF, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 32'h0, 1'b1, 32'h2004, 4'h3, 32'hBEEF, 1'b1, 32'h55,
                    1'b1, 32'h2004, 4'h3, 32'hBEEF, 1'b0, 32'h0, 1'b1, 32'h55};
        vecs[8] = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 32'h2004, 4'h3, 32'hBEEF, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[9] = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 32'h2004, 4'h3, 32'hBEEF, 1'b0, 32'h0, 1'b0, 32'h0};

        // Reset state, with a request pending to show nothing is granted under reset
        drive(1'b1, 32'h100, 1'b1, 32'h200, 4'hF, 32'h1, 1'b1, 32'h7);
        @(negedge clk);
        chk("reset bus_valid", 32'(a_bv), 32'h0);
        chk("reset bus_address", a_ba, 32'h0);
        chk("reset bus_mask", 32'(a_bm), 32'h0);
        chk("reset bus_value", a_bw, 32'h0);
        chk("reset readies", {30'h0, a_ir, a_dr}, 32'h0);
        chk("reset rdata", a_ird | a_drd, 32'h0);
        do_reset();

        // Directed vectors: instruction fetch, then data write with stalls and an instr pulse
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].da, vecs[i].dm, vecs[i].dw, vecs[i].br, vecs[i].brv);
            @(negedge clk);
            chk($sformatf("vec%0d bus_valid", i), 32'(a_bv), 32'(vecs[i].e_bv));
            chk($sformatf("vec%0d bus_address", i), a_ba, vecs[i].e_ba);
            chk($sformatf("vec%0d bus_mask", i), 32'(a_bm), 32'(vecs[i].e_bm));
            chk($sformatf("vec%0d bus_value", i), a_bw, vecs[i].e_bw);
            chk($sformatf("vec%0d instr_ready", i), 32'(a_ir), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d instr_rdata", i), a_ird, vecs[i].e_ird);
            chk($sformatf("vec%0d data_ready", i), 32'(a_dr), 32'(vecs[i].e_dr));
            chk($sformatf("vec%0d data_rdata", i), a_drd, vecs[i].e_drd);
            @(posedge clk);
            #1;
        end

        // Both requesting continuously
        do_reset();
        grant_run(20, -1, sa, sb);
        chk_str("order burst4", sa, "DDDDIDDDDI");
        chk_str("order burst1", sb, "DIDIDIDIDI");

        // Fetch drops out for the fourth data grant, which clears the burst count
        do_reset();
        grant_run(18, 6, sa, sb);
        chk_str("burst clear", sa, "DDDDDDDDI");

        // Async reset while DATA is in flight with a ready pending
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(1'b1, 32'h1000, 1'b1, 32'h2000, 4'hF, 32'h0, 1'b1, 32'h0);
            @(posedge clk);
            #1;
        end
        drive(1'b1, 32'h1000, 1'b1, 32'h2000, 4'hF, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("pre-reset bus_valid", 32'(a_bv), 32'h1);
        chk("pre-reset bus_address", a_ba, 32'h2000);
        #1;
        t_br = 1'b1;
        #1;
        chk("pre-reset data_ready", 32'(a_dr), 32'h1);
        reset = 1'b1;
        #1;
        chk("async reset bus_valid", 32'(a_bv), 32'h0);
        chk("async reset data_ready", 32'(a_dr), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset idle", 32'(a_bv), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post-reset first grant", a_ba, 32'h2000);
        chk("post-reset first valid", 32'(a_bv), 32'h1);
        @(posedge clk);
        #1;

        // Random traffic against the reference model, both burst limits at once
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(1)), $urandom() & 32'hFFFF_FFFC,
                  1'($urandom_range(1)), $urandom() & 32'hFFFF_FFFC,
                  ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15)), $urandom(),
                  1'($urandom_range(1)), $urandom());
            @(negedge clk);
            cmp_model(0, a_bv, a_ba, a_bm, a_bw, a_ir, a_ird, a_dr, a_drd);
            cmp_model(1, b_bv, b_ba, b_bm, b_bw, b_ir, b_ird, b_dr, b_drd);
            @(posedge clk);
            model_step();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
